// File: rtl/led_pkg.sv
// led_pkg: state encoding, default widths and BCM plane-weight helper for led_bcm_scheduler
package led_pkg;

    localparam int ADDR_BITS  = 5;
    localparam int PLANE_BITS = 2;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_FILL    = 7'b0000010,
        S_DISPLAY = 7'b0000100,
        S_WAIT    = 7'b0001000,
        S_BLANK   = 7'b0010000,
        S_DEAD    = 7'b0100000,
        S_LATCH   = 7'b1000000
    } state_t;

    function automatic int unsigned plane_weight(input int unsigned base, input int unsigned p);
        return base << p;
    endfunction

endpackage

// File: rtl/led_bcm_scheduler_dwell.sv
// led_dwell_timer: loadable down-counter timing one BCM plane's on-time
module led_dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    assign expired = value == '0;

    // load has priority; counting stops at zero
    always_ff @(posedge clk) begin
        if (reset) value <= '0;
        else if (load) value <= load_value;
        else if (count_en && !expired) value <= value - 1'b1;
    end

endmodule

// File: rtl/led_bcm_scheduler.sv
// led_bcm_scheduler: HUB75 row/bit-plane BCM scheduler; optional LED_BCM_DEADTIME_EN adds a blank hold before latch
module led_bcm_scheduler #(
    parameter int PLANES     = 4,
    parameter int ADDR_BITS  = led_pkg::ADDR_BITS,
    parameter int BASE_TICKS = 16,
    parameter int FRAME_BITS = 10,
    parameter int DEADTIME   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic                       shift_req,
    output logic [ADDR_BITS-1:0]       shift_addr,
    output logic [$clog2(PLANES)-1:0]  shift_plane,
    input  logic                       shift_done,
    output logic                       latch,
    output logic                       blank,
    output logic [ADDR_BITS-1:0]       led_addr,
    output logic [FRAME_BITS-1:0]      frame,
    output logic                       frame_start
);

    import led_pkg::*;

    localparam int PW = $clog2(PLANES);
    localparam int DW = $clog2(BASE_TICKS) + PLANES;

    state_t state, state_nx;
    logic shift_ok, done_now, expired, last_plane, dead_last, addr_take;
    logic [DW-1:0] unused_dwell_value;

    assign done_now   = shift_req && shift_done;
    assign last_plane = shift_plane == PW'(PLANES - 1);

    // dwell loads W-1 on the latch cycle so blank stays low exactly W cycles
    led_dwell_timer #(.WIDTH(DW)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .load       (state == S_LATCH),
        .load_value (DW'(plane_weight(BASE_TICKS, 32'(shift_plane)) - 1)),
        .count_en   (state == S_DISPLAY),
        .value      (unused_dwell_value),
        .expired    (expired)
    );

`ifdef LED_BCM_DEADTIME_EN
    localparam int CW = $clog2(DEADTIME + 1);
    localparam state_t HOLD_STATE = DEADTIME > 0 ? S_DEAD : S_LATCH;
    logic [CW-1:0] dead_cnt;
    assign dead_last = dead_cnt == CW'(DEADTIME - 1);
    assign addr_take = state == S_DEAD && dead_cnt == CW'(DEADTIME / 2);
    // cycles spent in the extra blank hold; row address switches at its midpoint
    always_ff @(posedge clk) dead_cnt <= (reset || state != S_DEAD) ? '0 : dead_cnt + 1'b1;
`else
    localparam state_t HOLD_STATE = S_LATCH;
    localparam int unused_deadtime = DEADTIME;
    assign dead_last = 1'b1;
    assign addr_take = state == S_LATCH;
`endif

    // next state and panel-side outputs
    always_comb begin
        state_nx    = state;
        blank       = state != S_DISPLAY;
        latch       = state == S_LATCH;
        frame_start = state == S_LATCH && shift_addr == '0 && shift_plane == '0;
        case (state)
            S_IDLE:    state_nx = enable ? S_FILL : S_IDLE;
            S_FILL:    state_nx = done_now ? S_BLANK : S_FILL;
            S_DISPLAY: state_nx = expired ? S_WAIT : S_DISPLAY;
            S_WAIT:    state_nx = (shift_ok || done_now) ? S_BLANK : S_WAIT;
            S_BLANK:   state_nx = enable ? HOLD_STATE : S_IDLE;
            S_DEAD:    state_nx = dead_last ? S_LATCH : S_DEAD;
            S_LATCH:   state_nx = S_DISPLAY;
            default:   state_nx = S_IDLE;
        endcase
    end

    // state register, shifter handshake, scan position, displayed row and frame count
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shift_req   <= 1'b0;
            shift_ok    <= 1'b0;
            shift_addr  <= '0;
            shift_plane <= '0;
            led_addr    <= '0;
            frame       <= '0;
        end else begin
            state <= state_nx;
            if (done_now) begin
                shift_req <= 1'b0;
                shift_ok  <= 1'b1;
            end
            if (addr_take) led_addr <= shift_addr;
            if (state == S_IDLE && enable) begin
                shift_req   <= 1'b1;
                shift_ok    <= 1'b0;
                shift_addr  <= '0;
                shift_plane <= '0;
            end
            if (state == S_BLANK && !enable) begin
                shift_addr  <= '0;
                shift_plane <= '0;
            end
            if (state == S_LATCH) begin
                shift_req   <= 1'b1;
                shift_ok    <= 1'b0;
                shift_plane <= last_plane ? '0 : shift_plane + 1'b1;
                if (last_plane) shift_addr <= shift_addr + 1'b1;
                if (frame_start) frame <= frame + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_bcm_scheduler.sv
// tb_led_bcm_scheduler: directed checks of BCM dwell widths, handshake, frame counting and reset behaviour
module tb_led_bcm_scheduler;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, shift_done = 1'b0;
    logic shift_req, latch, blank, frame_start;
    logic [4:0] shift_addr, led_addr;
    logic [1:0] shift_plane, frame;

    int errors = 0, checks = 0;
    int shift_delay = 3;
    int latch_count = 0, lo_run = 0, hi_run = 0, cur_addr = 0;
    bit seen_lo = 1'b0, fs_prev = 1'b0;
    int widths[$], addrs[$], gaps[$], fs_idx[$], frames[$];

    led_bcm_scheduler #(
        .PLANES(4), .ADDR_BITS(5), .BASE_TICKS(16), .FRAME_BITS(2), .DEADTIME(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .shift_req(shift_req), .shift_addr(shift_addr), .shift_plane(shift_plane),
        .shift_done(shift_done), .latch(latch), .blank(blank),
        .led_addr(led_addr), .frame(frame), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // shifter model: done pulses shift_delay cycles after it sees a request
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (shift_req) begin
                repeat (shift_delay - 1) @(posedge clk);
                #1 shift_done = 1'b1;
                @(posedge clk);
                #1 shift_done = 1'b0;
            end
        end
    end

    // records blank-low widths with displayed row, blank-high gaps, latches and frame starts
    always @(negedge clk) begin
        if (reset) begin
            lo_run = 0; hi_run = 0; seen_lo = 1'b0; fs_prev = 1'b0;
        end else begin
            if (fs_prev) frames.push_back(int'(frame));
            fs_prev = frame_start;
            if (frame_start) fs_idx.push_back(latch_count);
            if (latch) latch_count++;
            if (!blank) begin
                if (lo_run == 0 && seen_lo) gaps.push_back(hi_run);
                lo_run++; hi_run = 0; cur_addr = int'(led_addr);
            end else begin
                if (lo_run > 0) begin
                    widths.push_back(lo_run); addrs.push_back(cur_addr); seen_lo = 1'b1;
                end
                lo_run = 0; hi_run++;
            end
        end
    end

    initial begin
        int n, lc;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_shift_req", shift_req, 0);
        check("rst_shift_addr", shift_addr, 0);
        check("rst_shift_plane", shift_plane, 0);
        check("rst_latch", latch, 0);
        check("rst_blank", blank, 1);
        check("rst_led_addr", led_addr, 0);
        check("rst_frame", frame, 0);
        check("rst_frame_start", frame_start, 0);

        reset = 1'b0; enable = 1'b1;
        n = 0;
        while (!shift_req && n < 20) begin @(negedge clk); n++; end
        check("first_req", shift_req, 1);
        check("first_addr", shift_addr, 0);
        check("first_plane", shift_plane, 0);
        n = 0;
        while (!latch && n < 50) begin @(negedge clk); n++; end
        check("req_to_latch", n, 4);

        n = 0;
        while (latch_count < 407 && n < 40000) begin @(negedge clk); n++; end
        check("reach_row_5_2", int'(latch_count >= 407), 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (400) @(negedge clk);

        check("width_p0", widths[0], 16);
        check("width_p1", widths[1], 32);
        check("width_p2", widths[2], 64);
        check("width_p3", widths[3], 128);
        check("width_r1p0", widths[4], 16);
        check("addr_p0", addrs[0], 0);
        check("addr_p3", addrs[3], 0);
        check("addr_r1p0", addrs[4], 1);
        check("gap_fast", gaps[0], 3);
        check("fs_count", fs_idx.size(), 4);
        check("fs_idx0", fs_idx[0], 0);
        check("fs_idx1", fs_idx[1], 128);
        check("fs_idx2", fs_idx[2], 256);
        check("fs_idx3", fs_idx[3], 384);
        check("frame_after0", frames[0], 1);
        check("frame_after1", frames[1], 2);
        check("frame_after2", frames[2], 3);
        check("frame_wrap", frames[3], 0);
        check("drop_width_5_2", widths[406], 64);
        check("drop_addr_5_2", addrs[406], 5);
        check("drop_dwell_count", widths.size(), 407);
        check("drop_latch_count", latch_count, 407);
        check("idle_blank", blank, 1);
        check("idle_req", shift_req, 0);
        check("idle_frame_kept", frame, 0);

        enable = 1'b1;
        n = 0;
        while (!shift_req && n < 20) begin @(negedge clk); n++; end
        check("reen_req", shift_req, 1);
        check("reen_addr", shift_addr, 0);
        check("reen_plane", shift_plane, 0);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("midrst_req", shift_req, 0);
        check("midrst_blank", blank, 1);
        reset = 1'b0;
        lc = latch_count;
        repeat (30) @(negedge clk);
        check("spurious_no_latch", latch_count, lc);
        check("spurious_req", shift_req, 0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        widths.delete(); gaps.delete();
        shift_delay = 200;
        reset = 1'b0; enable = 1'b1;
        n = 0;
        while (widths.size() < 3 && n < 3000) begin @(negedge clk); n++; end
        check("slow_dwells", int'(widths.size() >= 3), 1);
        check("slow_width_p0", widths[0], 16);
        check("slow_width_p1", widths[1], 32);
        check("slow_width_p2", widths[2], 64);
        check("slow_gap_p0", gaps[0], 186);
        check("slow_gap_p1", gaps[1], 170);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
